// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: the default transform size,
// the sequencer state encoding and the derived width helpers.
// Optional feature macro: FFT_CTRL_IFFT_EN (inverse-transform twiddles).
package fft_pkg;

  localparam int N_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  // Address width: one bit per FFT stage.
  function automatic int aw_f(input int n_log2);
    return n_log2;
  endfunction

  // Stage number width.
  function automatic int sw_f(input int n_log2);
    return $clog2(n_log2);
  endfunction

  // Butterfly index and twiddle width (N/2 butterflies per stage).
  function automatic int kw_f(input int n_log2);
    return n_log2 - 1;
  endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Butterfly request / write-back bus between the stage sequencer (master)
// and the butterfly datapath (slave).
// Optional feature macro: FFT_CTRL_IFFT_EN adds the tw_conj flag.
interface fft_stage_ctrl_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) ();

  localparam int AW = aw_f(N_LOG2);
  localparam int KW = kw_f(N_LOG2);

  logic          bf_valid;
  logic          bf_ready;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [KW-1:0] tw_idx;
  logic          wb_valid;

`ifdef FFT_CTRL_IFFT_EN
  logic          tw_conj;

  modport master (
    output bf_valid, addr_a, addr_b, tw_idx, tw_conj,
    input  bf_ready, wb_valid
  );

  modport slave (
    input  bf_valid, addr_a, addr_b, tw_idx, tw_conj,
    output bf_ready, wb_valid
  );
`else
  modport master (
    output bf_valid, addr_a, addr_b, tw_idx,
    input  bf_ready, wb_valid
  );

  modport slave (
    input  bf_valid, addr_a, addr_b, tw_idx,
    output bf_ready, wb_valid
  );
`endif

endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place address and twiddle mapping for butterfly k of stage s.
// The high part of k (above the stage span) selects the butterfly group, the
// low part is the position inside the group; a zero bit is inserted at the
// span position to form addr_a, and addr_b sits one span higher.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter  int N_LOG2 = N_LOG2_DEF,
  localparam int AW     = aw_f(N_LOG2),
  localparam int SW     = sw_f(N_LOG2),
  localparam int KW     = kw_f(N_LOG2)
) (
  input  logic [SW-1:0] s,
  input  logic [KW-1:0] k,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [KW-1:0] tw_idx
);

  logic [KW-1:0] hi_mask_s;
  logic [KW-1:0] hi_s;
  logic [KW-1:0] pos_s;
  logic [AW-1:0] span_s;
  logic [AW-1:0] addr_a_s;
  logic [SW-1:0] tw_sh_s;

  // Split k at the stage span and rebuild the two butterfly addresses
  always_comb begin
    hi_mask_s = {KW{1'b1}} << s;
    hi_s      = k & hi_mask_s;
    pos_s     = k & ~hi_mask_s;
    span_s    = AW'(1'b1) << s;
    addr_a_s  = {hi_s, 1'b0} | {1'b0, pos_s};
    tw_sh_s   = SW'(KW) - s;
  end

  assign addr_a = addr_a_s;
  assign addr_b = addr_a_s + span_s;
  assign tw_idx = pos_s << tw_sh_s;

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for the in-place radix-2 DIT FFT: issues one butterfly
// request per accepted cycle, waits for every write-back of a stage before
// starting the next one, and pulses done after the last stage.
// Optional feature macro: FFT_CTRL_IFFT_EN adds the inverse input and the
// conjugated-twiddle flag tw_conj on the butterfly bus.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter  int N_LOG2 = N_LOG2_DEF,
  localparam int AW     = aw_f(N_LOG2),
  localparam int SW     = sw_f(N_LOG2),
  localparam int KW     = kw_f(N_LOG2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
`ifdef FFT_CTRL_IFFT_EN
  input  logic            inverse,
`endif
  fft_stage_ctrl_if.master bf,
  output logic [SW-1:0]   stage,
  output logic            busy,
  output logic            done
);

  localparam logic [KW-1:0] K_LAST  = {KW{1'b1}};
  localparam logic [KW:0]   WB_FULL = {1'b1, {KW{1'b0}}};
  localparam logic [SW-1:0] S_LAST  = SW'(N_LOG2 - 1);

  fft_state_e    state_r, state_nxt_s;
  logic [SW-1:0] stage_r, stage_nxt_s;
  logic [KW-1:0] k_r, k_nxt_s;
  logic [KW:0]   wb_cnt_r, wb_cnt_nxt_s;
  logic          accept_s;
  logic          wb_cnt_en_s;

  logic [AW-1:0] gen_a_s, gen_b_s;
  logic [KW-1:0] gen_tw_s, tw_out_s;
  logic [AW-1:0] addr_a_r, addr_b_r;
  logic [KW-1:0] tw_idx_r;
  logic          bf_valid_r, busy_r, done_r;

  assign accept_s    = (state_r == ST_RUN) && bf.bf_ready;
  assign wb_cnt_en_s = ((state_r == ST_RUN) || (state_r == ST_DRAIN))
                       && bf.wb_valid && (wb_cnt_r != WB_FULL);

  // Next state, stage, butterfly index and write-back count; abort wins
  always_comb begin
    state_nxt_s  = state_r;
    stage_nxt_s  = stage_r;
    k_nxt_s      = k_r;
    if (wb_cnt_en_s) begin
      wb_cnt_nxt_s = wb_cnt_r + (KW + 1)'(1'b1);
    end else begin
      wb_cnt_nxt_s = wb_cnt_r;
    end

    if (abort) begin
      state_nxt_s  = ST_IDLE;
      stage_nxt_s  = '0;
      k_nxt_s      = '0;
      wb_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s  = ST_RUN;
            stage_nxt_s  = '0;
            k_nxt_s      = '0;
            wb_cnt_nxt_s = '0;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            k_nxt_s = k_r + KW'(1'b1);
            if (k_r == K_LAST) begin
              state_nxt_s = ST_DRAIN;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Uses the registered count, so DRAIN always lasts at least a cycle
          if (wb_cnt_r == WB_FULL) begin
            if (stage_r == S_LAST) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s  = ST_RUN;
              stage_nxt_s  = stage_r + SW'(1'b1);
              k_nxt_s      = '0;
              wb_cnt_nxt_s = '0;
            end
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          stage_nxt_s  = '0;
          k_nxt_s      = '0;
          wb_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Addresses are generated for the next (stage, k) so they can be registered;
  // while stalled (stage, k) does not move, which keeps the request stable
  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .s      (stage_nxt_s),
    .k      (k_nxt_s),
    .addr_a (gen_a_s),
    .addr_b (gen_b_s),
    .tw_idx (gen_tw_s)
  );

`ifdef FFT_CTRL_IFFT_EN
  logic inverse_r, inverse_nxt_s, tw_conj_r;

  // Direction is captured when a start is taken and held for the transform
  always_comb begin
    inverse_nxt_s = inverse_r;
    if (abort) begin
      inverse_nxt_s = 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      inverse_nxt_s = inverse;
    end else begin
      inverse_nxt_s = inverse_r;
    end
  end

  // For the inverse transform the twiddle index is negated modulo N
  assign tw_out_s = inverse_nxt_s ? ({KW{1'b0}} - gen_tw_s) : gen_tw_s;

  // Direction register and conjugate flag on the butterfly bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inverse_r <= 1'b0;
      tw_conj_r <= 1'b0;
    end else begin
      inverse_r <= inverse_nxt_s;
      tw_conj_r <= inverse_nxt_s && (state_nxt_s != ST_IDLE);
    end
  end

  assign bf.tw_conj = tw_conj_r;
`else
  assign tw_out_s = gen_tw_s;
`endif

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      stage_r    <= '0;
      k_r        <= '0;
      wb_cnt_r   <= '0;
      bf_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      addr_a_r   <= '0;
      addr_b_r   <= '0;
      tw_idx_r   <= '0;
    end else begin
      state_r    <= state_nxt_s;
      stage_r    <= stage_nxt_s;
      k_r        <= k_nxt_s;
      wb_cnt_r   <= wb_cnt_nxt_s;
      bf_valid_r <= (state_nxt_s == ST_RUN);
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_nxt_s == ST_DONE);
      addr_a_r   <= gen_a_s;
      addr_b_r   <= gen_b_s;
      tw_idx_r   <= tw_out_s;
    end
  end

  assign bf.bf_valid = bf_valid_r;
  assign bf.addr_a   = addr_a_r;
  assign bf.addr_b   = addr_b_r;
  assign bf.tw_idx   = tw_idx_r;
  assign stage       = stage_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Stage sequencer for the in-place radix-2 DIT FFT core. It runs all log2(N) stages back to back and issues one butterfly request per cycle to the butterfly unit over a valid/ready handshake, with the A/B memory addresses and twiddle index for each request. Before starting the next stage it counts write-back acknowledgements, so a stage never reads data the previous stage has not yet written. It sits between the top-level start/done interface and the butterfly/RAM datapath, and replaces ad-hoc per-stage counters.

## Interface
- N_LOG2, default 8: log2 of the FFT size. Legal range 2..10; the default gives 256 points, 8 stages and 128 butterflies per stage.
- Derived constants:
  - AW = N_LOG2: address width.
  - SW = clog2(N_LOG2): stage width.
  - KW = N_LOG2-1: butterfly index width and twiddle width.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin a transform. Honoured only in IDLE.
- abort, input, 1: synchronous cancel. Returns the block to IDLE on the next edge.
- bf_valid, output, 1: a butterfly request is presented.
- bf_ready, input, 1: the butterfly unit accepts the request.
- addr_a, output, AW: upper input/output address of the butterfly.
- addr_b, output, AW: lower input/output address of the butterfly.
- tw_idx, output, KW: twiddle ROM index.
- stage, output, SW: current stage number.
- wb_valid, input, 1: one pulse per completed butterfly write-back.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the last stage has completed.

## Operation
- State machine states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 moves to RUN with stage=0, k=0 and wb_cnt=0.
- RUN:
  - bf_valid=1.
  - k advances on bf_valid&&bf_ready.
  - When the transfer with k=2^KW-1 is accepted, go to DRAIN.
- DRAIN:
  - bf_valid=0.
  - Wait until wb_cnt reaches 2^KW.
  - If that is the last stage (stage=N_LOG2-1), go to DONE.
  - Otherwise stage increments, k and wb_cnt clear, and the state returns to RUN.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
- Address and twiddle generation (combinational from stage s and k):
  - span = 1<<s.
  - pos = k & (span-1).
  - addr_a = ((k>>s)<<(s+1)) | pos.
  - addr_b = addr_a + span.
  - tw_idx = pos << (KW-s), truncated to KW bits.
- Outputs are held stable while bf_valid=1 and bf_ready=0.
- wb_cnt:
  - Increments on wb_valid in the RUN and DRAIN states.
  - Saturates at 2^KW.
  - Is ignored in IDLE and DONE.
- start while busy=1 is ignored and not queued.
- abort has priority over every other event.
  - It clears k, stage and wb_cnt and returns to IDLE.
  - No done pulse is produced.
- If wb_valid and the final bf accept occur in the same cycle, both take effect.

## Timing
- Reset values: state=IDLE; bf_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, busy=0, done=0; internal counters 0.
- busy is registered:
  - It goes high the cycle after start.
  - It goes low the cycle after the done pulse.
- First bf_valid appears 1 cycle after start.
- With bf_ready held at 1, one butterfly is issued per clock.
- DRAIN lasts at least 1 cycle, even if all write-backs have already arrived.
- Minimum transform time: N_LOG2·(2^KW+1)+2 cycles. For 256 points this is 1034 cycles.

## Configuration
- FFT_CTRL_IFFT_EN, when defined:
  - Adds an input inverse (1 bit), sampled at start and held for the whole transform.
  - When inverse=1, tw_idx is replaced by (2^N_LOG2 - tw_idx) mod 2^N_LOG2, truncated to KW bits and flagged by an added output tw_conj=1.
  - tw_conj resets to 0.
- FFT_CTRL_IFFT_EN, when undefined:
  - Neither port exists.
  - Twiddle generation is forward only.

## Structure
- Shared package fft_pkg holds:
  - the N_LOG2 default;
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the AW/SW/KW width functions.
- One sub-module, fft_addr_gen: a purely combinational mapping (s, k) -> addr_a, addr_b, tw_idx, instantiated once.

## Test plan
1. Reset, then start with bf_ready=1 and wb_valid echoed 2 cycles after each accept:
   - 8 stages with 128 accepts each.
   - done pulses exactly once.
   - busy stays high until the cycle after done.
2. Stage 0, k=5:
   - addr_a=10, addr_b=11, tw_idx=0.
3. Stage 7, k=5:
   - addr_a=5, addr_b=133, tw_idx=5.
4. bf_ready toggled randomly:
   - Address, twiddle and stage outputs stay stable while stalled.
   - Each (addr_a, addr_b) pair is issued exactly once per stage.
5. Withhold the last write-back of stage 3 for 20 cycles:
   - stage remains 3 and bf_valid=0 until the write-back arrives.
   - RUN then resumes with stage=4 and k=0.
6. abort during stage 2 RUN, and start asserted while busy:
   - After abort: IDLE next cycle, busy=0, no done pulse.
   - The start while busy is ignored.
   - A new start restarts from stage 0.
